// File: rtl/pseg_counter_if.sv
// Handshake bundle for pseg_counter: control/load inputs and count/status outputs.
interface pseg_counter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             en_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0] value_o;
    logic             busy_o;
    logic             wrap_o;

    modport master (
        output en_i, load_i, load_val_i,
        input  value_o, busy_o, wrap_o
    );

    modport slave (
        input  en_i, load_i, load_val_i,
        output value_o, busy_o, wrap_o
    );
endinterface

// File: rtl/pseg_counter.sv
// Pipelined binary up-counter: SEG-bit segments with registered carries between them,
// so the critical path is one SEG-bit increment regardless of WIDTH.
module pseg_counter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input logic          clk_i,
    input logic          rst_i,
    pseg_counter_if.slave bus
);
    localparam int unsigned NSEG = (WIDTH + SEG - 1) / SEG;
    localparam int unsigned TOPW = WIDTH - (NSEG - 1) * SEG;

    logic [WIDTH-1:0] value_q, value_d, seg_next;
    // Bit 0 is tied off: segment 0 is fed by en_i, and busy reduces cleanly to 0 when NSEG=1.
    logic [NSEG-1:0]  cin_q, cin_d;
    logic [NSEG-1:0]  inc, seg_carry;
    logic             wrap_q, wrap_d;

    assign inc = cin_q | NSEG'(bus.en_i);

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int unsigned SegW = (k == NSEG - 1) ? TOPW : SEG;
        logic [SegW-1:0] seg;
        assign seg                        = value_q[k*SEG +: SegW];
        assign seg_next[k*SEG +: SegW]    = inc[k] ? seg + SegW'(1) : seg;
        assign seg_carry[k]               = inc[k] & (&seg);
    end

    always_comb begin
        value_d = value_q;
        cin_d   = '0;
        wrap_d  = 1'b0;
        if (bus.load_i) begin
            // Load wins over en_i and drops any carries still in flight.
            value_d = bus.load_val_i;
        end else begin
            value_d = seg_next;
            cin_d   = seg_carry << 1;
            wrap_d  = seg_carry[NSEG-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= '0;
            cin_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            cin_q   <= cin_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.value_o = value_q;
    assign bus.busy_o  = |cin_q;
    assign bus.wrap_o  = wrap_q;
endmodule

// File: doc/pseg_counter.md
# pseg_counter

Parametrised pipelined binary up-counter. The count is split into SEG-bit segments, and the carry between adjacent segments is registered, so the critical path is one SEG-bit increment regardless of WIDTH. This is the next generation of the per-bit pipelined counter: SEG=1 reproduces it exactly. It adds a synchronous load, a carries-in-flight indicator and a wrap pulse, and serves as the free-running event and timestamp counter in the counter subsystem.

## Interface
- WIDTH, 16: counter width in bits; legal range 1 and up.
- SEG, 4: bits per pipeline segment; legal range 1..WIDTH. NSEG = ceil(WIDTH/SEG). The top segment is WIDTH-(NSEG-1)*SEG bits wide.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- en_i  in  1  increment request for this cycle.
- load_i  in  1  synchronous load strobe.
- load_val_i  in  WIDTH  value written on load.
- value_o  out  WIDTH  registered count.
- busy_o  out  1  high while any inter-segment carry is pending.
- wrap_o  out  1  registered one-cycle pulse when the top segment overflows.

## Operation
- **State:** NSEG segment registers seg[k] = value_o[k*SEG +: width_k], plus carry registers cin[k] for k = 1..NSEG-1. The increment input of segment 0 is en_i.
- **Segment k increment:** seg[k] <= seg[k]+1, modulo 2^width_k, when its increment input (en_i for k=0, cin[k] otherwise) is 1.
- **Carry out:** every edge, cin[k+1] <= inc[k] & (seg[k] == all ones). The term is 0 when there is no increment, so it is not sticky.
- **Wrap:** wrap_o <= inc[NSEG-1] & (seg[NSEG-1] == all ones). This covers every edge where the top segment rolls over to 0.
- **busy_o:** OR of all cin[k], driven combinationally from registers. busy_o is constant 0 when NSEG=1.
- **Load:**
  - When load_i=1, value_o <= load_val_i and all cin <= 0.
  - wrap_o <= 0 on a load edge.
  - en_i in the same cycle is ignored.
  - Load has priority over en_i and over any pending carries, which are discarded.
- **Invariant:** value_o + sum over k of cin[k]·2^(k*SEG) equals the true count modulo 2^WIDTH. This holds whenever no load occurred since the increments being counted.
- **Collisions:** none are possible. A segment receives at most one increment per edge, and a carry is generated at most once per 2^SEG increments of the segment below. No arbitration logic is required.
- **Reset:** asynchronous. It forces value_o=0, all cin=0, busy_o=0 and wrap_o=0 regardless of operations in flight, and takes effect immediately on assertion.

## Timing
- en_i sampled high at edge t: segment 0 updates at edge t.
- A resulting carry into segment k updates seg[k] at edge t+k.
- Full-width settle: value_o is exact NSEG-1 edges after the last en_i. busy_o is guaranteed low by then.
- wrap_o rises at the same edge the top segment becomes 0 (edge t+NSEG-1 after the originating en_i) and is high for exactly one cycle.
- Continuous en_i: the counter sustains 1 increment/cycle indefinitely. The value lags the true count by the pending carries only; there is no throughput loss.
- Load: value_o = load_val_i visible after the load edge. The first en_i in the following cycle increments from that value.
- Reset release: the first en_i edge after release increments from 0.
- All outputs are registered except busy_o, which is an OR of registers.

## Test plan
1. **Reset (WIDTH=8, SEG=4):** assert rst_i mid-count with carries pending -> value_o=0x00, busy_o=0 and wrap_o=0 immediately, without waiting for a clock edge.
2. **Single carry:** from 0, issue 16 isolated en_i pulses.
   - After pulse 16: value_o=0x00 at that edge with busy_o=1, then 0x10 one edge later with busy_o=0.
   - busy_o is high for exactly 1 cycle.
3. **Continuous wrap:** en_i held for 256 cycles from 0 -> wrap_o pulses exactly once, and value_o=0x00 with busy_o=0 one idle cycle later. A scoreboard checks the invariant every cycle.
4. **Load priority:** load_i=1, load_val_i=0xEF and en_i=1 in the same cycle -> value_o=0xEF. One further en_i then gives 0xE0, then 0xF0 next edge.
5. **Load discards carry:** value_o=0x0F, one en_i (carry pending), load 0x55 next cycle -> value_o=0x55, busy_o=0, and 0x65 never appears.
6. **Parameter sweep:**
   - WIDTH=4, SEG=1: matches the per-bit counter cycle-for-cycle.
   - WIDTH=10, SEG=4 (2-bit top segment): wrap_o fires once per 1024 increments and value_o settles at 0x000.
